// File: rtl/instr_mem_pkg.sv
// Shared constants for the pipelined instruction store.
package instr_mem_pkg;

    // Value returned in place of an instruction on any fault: addi x0, x0, 0.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Bit positions inside the 2-bit fault field.
    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and synchronous flush.
// The head is forced to zero while empty, so it never exposes stale entries.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Storage is rounded up to a power of two so every pointer value indexes a real entry.
    logic [WIDTH-1:0] mem_q [2**PW];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    // Next pointer/count; flush wins over any simultaneous push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count state, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; no reset needed since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/instr_mem_pipe.sv
// Synchronous-read instruction store with valid/ready request and buffered
// response channels, program-load port, fault decode and flush.
module instr_mem_pipe
    import instr_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 512,
    parameter int RSP_DEPTH  = 3,
    parameter     INIT_FILE  = ""
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_instr,
    output logic [ADDR_WIDTH-1:0]       rsp_addr,
    output logic [1:0]                  rsp_fault,
    input  logic                        flush,
    input  logic                        ld_en,
    input  logic [$clog2(MEM_SIZE)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]       ld_data
);
    localparam int W  = $clog2(MEM_SIZE);
    localparam int CW = $clog2(RSP_DEPTH+1);
    localparam int FW = ADDR_WIDTH + 2 + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic                  accept;
    logic [1:0]            fault_d;
    logic [DATA_WIDTH-1:0] instr_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [1:0]            s1_fault_q;
    logic [DATA_WIDTH-1:0] s1_instr_q;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credits_used;
    logic [FW-1:0]         fifo_head;

    // Credits count only registered state, keeping rsp_ready off the req_ready path.
    assign credits_used = {1'b0, fifo_count} + (CW+1)'(s1_valid_q);
    assign req_ready    = !flush && (credits_used < (CW+1)'(RSP_DEPTH));
    assign accept       = req_valid && req_ready;

    // Fault decode; any fault replaces the fetched word with a NOP.
    always_comb begin
        fault_d                 = '0;
        fault_d[FAULT_MISALIGN] = |req_addr[1:0];
        fault_d[FAULT_RANGE]    = |req_addr[ADDR_WIDTH-1:W+2];
        instr_d                 = (|fault_d) ? DATA_WIDTH'(NOP_INSTR) : mem[req_addr[W+1:2]];
    end

    // Flush already blocks accept, so it also clears S1.
    assign s1_valid_d = accept;

    // Program-load write; a same-edge read in S1 sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    // S1 valid bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) s1_valid_q <= 1'b0;
        else       s1_valid_q <= s1_valid_d;
    end

    // S1 payload, only captured on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_addr_q  <= req_addr;
            s1_fault_q <= fault_d;
            s1_instr_q <= instr_d;
        end
    end

    // Response buffer; S1 always has room thanks to the credit rule.
    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .push_i  (s1_valid_q),
        .data_i  ({s1_addr_q, s1_fault_q, s1_instr_q}),
        .pop_i   (rsp_ready),
        .valid_o (rsp_valid),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign {rsp_addr, rsp_fault, rsp_instr} = fifo_head;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench for instr_mem_pipe with default parameters.
module tb_instr_mem_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_instr, rsp_addr;
    logic [1:0]  rsp_fault;
    logic        flush, ld_en;
    logic [8:0]  ld_addr;
    logic [31:0] ld_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [4];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    instr_mem_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ld(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Waits (bounded) for a response, starting from a negedge.
    task automatic wait_rsp();
        int n = 0;
        #1;
        while (!rsp_valid && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rsp_arrived", rsp_valid, 1);
    endtask

    task automatic single_req(input string nm, input logic [31:0] a,
                              input logic [31:0] ei, input logic [1:0] ef);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a;
        #1 chk({nm, "_ready"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp();
        chk({nm, "_instr"}, rsp_instr, ei);
        chk({nm, "_fault"}, rsp_fault, ef);
        chk({nm, "_addr"},  rsp_addr,  a);
        @(negedge clk);
        #1 chk({nm, "_drained"}, rsp_valid, 0);
    endtask

    initial begin
        int accepts;
        prog[0] = 32'h0050_0093; prog[1] = 32'h0010_0113;
        prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_006F;
        vecs[0] = '{32'h0000_0006, 32'h0000_0013, 2'b01};
        vecs[1] = '{32'h0000_0800, 32'h0000_0013, 2'b10};
        vecs[2] = '{32'h0000_0802, 32'h0000_0013, 2'b11};
        vecs[3] = '{32'h0000_0008, 32'h0020_81B3, 2'b00};
        vecs[4] = '{32'h0000_07FC, 32'hCAFE_F00D, 2'b00};
        vecs[5] = '{32'h8000_0000, 32'h0000_0013, 2'b10};
        vecs[6] = '{32'h0000_07FF, 32'h0000_0013, 2'b01};

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // Reset values
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_instr", rsp_instr, 0);
        chk("rst_rsp_addr",  rsp_addr,  0);
        chk("rst_rsp_fault", rsp_fault, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) ld(9'(i), prog[i]);
        ld(9'd5,   32'h1111_1111);
        ld(9'd511, 32'hCAFE_F00D);

        // Back-to-back stream: first response two edges after accept, then one per cycle
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 3) req_addr = 32'((k + 1) * 4);
            else       req_valid = 1'b0;
            #1;
            if (k == 0 || k == 5) chk("stream_idle", rsp_valid, 0);
            else begin
                chk("stream_valid", rsp_valid, 1);
                chk("stream_instr", rsp_instr, prog[k-1]);
                chk("stream_fault", rsp_fault, 0);
                chk("stream_addr",  rsp_addr,  32'((k - 1) * 4));
            end
            if (k < 3) chk("stream_ready", req_ready, 1);
        end

        // Fault and boundary table
        foreach (vecs[i]) single_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].fault);

        // Back-pressure: three accepts, then stall; drain in order
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0; accepts = 0;
        for (int k = 0; k < 6; k++) begin
            #1 if (req_ready) accepts++;
            @(negedge clk);
            req_addr = 32'(accepts * 4);
        end
        req_valid = 1'b0;
        #1;
        chk("bp_accepts", 64'(accepts), 3);
        chk("bp_ready_low", req_ready, 0);
        chk("bp_head_valid", rsp_valid, 1);
        chk("bp_head_instr", rsp_instr, prog[0]);
        @(negedge clk);
        #1 chk("bp_head_stable", rsp_instr, prog[0]);
        chk("bp_head_addr", rsp_addr, 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_drain_instr", rsp_instr, prog[i]);
            @(negedge clk);
        end
        #1 chk("bp_drained", rsp_valid, 0);

        // Read-before-write on the load port
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 9'd5; ld_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_addr = 32'h14;
        @(negedge clk);
        ld_en = 1'b0; req_valid = 1'b0;
        wait_rsp();
        chk("rbw_old", rsp_instr, 32'h1111_1111);
        @(negedge clk);
        single_req("rbw_new", 32'h14, 32'hDEAD_BEEF, 2'b00);

        // Flush with two buffered and one in S1, coinciding with a pop
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
        @(negedge clk); req_addr = 32'h4;
        @(negedge clk); req_addr = 32'h8;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("flush_ready_low", req_ready, 0);
        chk("flush_pre_valid", rsp_valid, 1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_empty", rsp_valid, 0);
        chk("flush_ready", req_ready, 1);
        @(negedge clk);
        #1 chk("flush_no_s1", rsp_valid, 0);
        single_req("flush_new", 32'hC, prog[3], 2'b00);

        // Asynchronous reset mid-stream
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
        @(negedge clk); req_addr = 32'h4;
        @(negedge clk); req_valid = 1'b0;
        #1 chk("arst_pre_valid", rsp_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_instr", rsp_instr, 0);
        chk("arst_addr",  rsp_addr,  0);
        chk("arst_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b0; rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk("arst_empty", rsp_valid, 0);
        end
        single_req("arst_mem_kept", 32'h4, prog[1], 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end

endmodule
